dvfs_governor: RTL and testbench

- Downstream consumer of the utilization counter. Takes the per-window utilization sample and decides the DVFS operating level, with hysteresis.
- Sequences each level change safely through req/ack handshakes to the voltage regulator and the clock generator.
- Voltage rises before frequency on step-up. Frequency falls before voltage on step-down.
- Sits between the performance counter and the power-management interface (PMIC/PLL wrappers).

---
 rtl/dvfs_pkg.sv | 32 +++
 rtl/dvfs_hyst_filter.sv | 72 +++++++
 rtl/dvfs_governor.sv | 152 +++++++++++++++
 tb/tb_dvfs_governor.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dvfs_pkg.sv
// DVFS governor shared types, defaults and helpers.
// Level 0 is the lowest voltage/frequency operating point.
package dvfs_pkg;

  localparam int DEF_NUM_LEVELS  = 4;
  localparam int DEF_LVL_W       = 2;
  localparam int DEF_UP_THRESH   = 80;
  localparam int DEF_DOWN_THRESH = 30;
  localparam int DEF_UP_HYST     = 2;
  localparam int DEF_DOWN_HYST   = 4;
  localparam int DEF_TIMEOUT     = 255;
  localparam int DEF_RESET_LEVEL = 0;
  localparam int UTIL_MAX        = 100;

  typedef logic [DEF_LVL_W-1:0] level_t;

  typedef enum logic [2:0] {
    IDLE,
    VOLT_UP,
    FREQ_UP,
    FREQ_DOWN,
    VOLT_DOWN,
    FAULT
  } dvfs_state_e;

  function automatic logic [15:0] util_sat(
    input logic [15:0] u
  );
    return (u > 16'(UTIL_MAX)) ? 16'(UTIL_MAX) : u;
  endfunction

endpackage

// File: rtl/dvfs_hyst_filter.sv
// Classifies utilization samples and counts consecutive
// high/low runs, flagging when a step is warranted.
module dvfs_hyst_filter
  import dvfs_pkg::*;
#(
  parameter int UP_THRESH   = DEF_UP_THRESH,
  parameter int DOWN_THRESH = DEF_DOWN_THRESH,
  parameter int UP_HYST     = DEF_UP_HYST,
  parameter int DOWN_HYST   = DEF_DOWN_HYST
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sample_en,
  input  logic [15:0] util_percent,
  input  logic        clear,
  output logic        step_up_req,
  output logic        step_down_req
);

  localparam int UW = $clog2(UP_HYST + 1);
  localparam int DW = $clog2(DOWN_HYST + 1);
  localparam logic [UW-1:0] UP_SAT = UW'(UP_HYST);
  localparam logic [DW-1:0] DN_SAT = DW'(DOWN_HYST);

  logic [15:0]   util;
  logic          high;
  logic          low;
  logic [UW-1:0] up_cnt;
  logic [UW-1:0] up_nxt;
  logic [DW-1:0] dn_cnt;
  logic [DW-1:0] dn_nxt;

  assign util = util_sat(util_percent);
  assign high = (util >= 16'(UP_THRESH));
  assign low  = (util <= 16'(DOWN_THRESH));

  // Counters saturate so a blocked step retries on the next sample.
  always_comb begin
    up_nxt = up_cnt;
    dn_nxt = dn_cnt;
    if (sample_en) begin
      unique case (1'b1)
        high: begin
          up_nxt = (up_cnt == UP_SAT) ? up_cnt : up_cnt + 1'b1;
          dn_nxt = '0;
        end
        low: begin
          dn_nxt = (dn_cnt == DN_SAT) ? dn_cnt : dn_cnt + 1'b1;
          up_nxt = '0;
        end
        default: begin
          up_nxt = '0;
          dn_nxt = '0;
        end
      endcase
    end
  end

  assign step_up_req   = sample_en && high && (up_nxt == UP_SAT);
  assign step_down_req = sample_en && low && (dn_nxt == DN_SAT);

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      up_cnt <= '0;
      dn_cnt <= '0;
    end else begin
      up_cnt <= up_nxt;
      dn_cnt <= dn_nxt;
    end
  end

endmodule

// File: rtl/dvfs_governor.sv
// DVFS governor: hysteresis-filtered level decisions sequenced
// through regulator and clock-generator req/ack handshakes.
module dvfs_governor
  import dvfs_pkg::*;
#(
  parameter int NUM_LEVELS  = DEF_NUM_LEVELS,
  parameter int LVL_W       = DEF_LVL_W,
  parameter int UP_THRESH   = DEF_UP_THRESH,
  parameter int DOWN_THRESH = DEF_DOWN_THRESH,
  parameter int UP_HYST     = DEF_UP_HYST,
  parameter int DOWN_HYST   = DEF_DOWN_HYST,
  parameter int TIMEOUT     = DEF_TIMEOUT,
  parameter int RESET_LEVEL = DEF_RESET_LEVEL
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      util_percent,
  input  logic             util_valid,
  input  logic             enable,
  input  logic             err_clr,
  output logic             vr_req,
  output logic [LVL_W-1:0] vr_level,
  input  logic             vr_ack,
  output logic             clk_req,
  output logic [LVL_W-1:0] clk_level,
  input  logic             clk_ack,
  output logic [LVL_W-1:0] cur_level,
  output logic             busy,
  output logic             timeout_err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [LVL_W-1:0] MAX_LVL = LVL_W'(NUM_LEVELS - 1);
  localparam logic [LVL_W-1:0] RST_LVL = LVL_W'(RESET_LEVEL);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  dvfs_state_e      state;
  dvfs_state_e      state_nxt;
  logic [LVL_W-1:0] target;
  logic [LVL_W-1:0] tgt_nxt;
  logic [TW-1:0]    timer;
  logic             tmo;
  logic             commit;
  logic             step_up_req;
  logic             step_down_req;
  logic             filt_clr;
  logic             enter_volt;
  logic             enter_freq;

  assign tmo      = (timer == TMO_LAST);
  assign filt_clr = (state_nxt != IDLE);

  dvfs_hyst_filter #(
    .UP_THRESH   (UP_THRESH),
    .DOWN_THRESH (DOWN_THRESH),
    .UP_HYST     (UP_HYST),
    .DOWN_HYST   (DOWN_HYST)
  ) u_filt (
    .clk           (clk),
    .rst_n         (rst_n),
    .sample_en     ((state == IDLE) && util_valid),
    .util_percent  (util_percent),
    .clear         (filt_clr),
    .step_up_req   (step_up_req),
    .step_down_req (step_down_req)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Ack is checked before the timer so a last-cycle ack wins.
  always_comb begin
    state_nxt = state;
    tgt_nxt   = target;
    commit    = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable && step_up_req && cur_level != MAX_LVL) begin
          state_nxt = VOLT_UP;
          tgt_nxt   = cur_level + 1'b1;
        end else if (enable && step_down_req && cur_level != '0) begin
          state_nxt = FREQ_DOWN;
          tgt_nxt   = cur_level - 1'b1;
        end
      end
      VOLT_UP: begin
        if (vr_ack)   state_nxt = FREQ_UP;
        else if (tmo) state_nxt = FAULT;
      end
      FREQ_UP: begin
        if (clk_ack) begin
          state_nxt = IDLE;
          commit    = 1'b1;
        end else if (tmo) begin
          state_nxt = FAULT;
        end
      end
      FREQ_DOWN: begin
        if (clk_ack)  state_nxt = VOLT_DOWN;
        else if (tmo) state_nxt = FAULT;
      end
      VOLT_DOWN: begin
        if (vr_ack) begin
          state_nxt = IDLE;
          commit    = 1'b1;
        end else if (tmo) begin
          state_nxt = FAULT;
        end
      end
      FAULT: begin
        if (err_clr) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    vr_req  = (state == VOLT_UP) || (state == VOLT_DOWN);
    clk_req = (state == FREQ_UP) || (state == FREQ_DOWN);
    busy    = (state != IDLE) && (state != FAULT);
  end

  assign enter_volt = (state_nxt != state) &&
                      (state_nxt == VOLT_UP || state_nxt == VOLT_DOWN);
  assign enter_freq = (state_nxt != state) &&
                      (state_nxt == FREQ_UP || state_nxt == FREQ_DOWN);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_level   <= RST_LVL;
      vr_level    <= RST_LVL;
      clk_level   <= RST_LVL;
      target      <= RST_LVL;
      timer       <= '0;
      timeout_err <= 1'b0;
    end else begin
      target <= tgt_nxt;
      if (state_nxt != state) timer <= '0;
      else if (busy)          timer <= timer + 1'b1;
      if (commit)     cur_level <= target;
      if (enter_volt) vr_level  <= tgt_nxt;
      if (enter_freq) clk_level <= tgt_nxt;
      if (state_nxt == FAULT && state != FAULT)
        timeout_err <= 1'b1;
      else if (state == FAULT && err_clr)
        timeout_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dvfs_governor.sv
// Bench for dvfs_governor: directed scenarios plus random
// traffic, checked every cycle against a transaction model.
module tb_dvfs_governor;
  import dvfs_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] util_percent = '0;
  logic        util_valid = 1'b0;
  logic        enable = 1'b1;
  logic        err_clr = 1'b0;
  logic        vr_ack = 1'b0;
  logic        clk_ack = 1'b0;
  logic        vr_req;
  logic        clk_req;
  logic        busy;
  logic        timeout_err;
  level_t      vr_level;
  level_t      clk_level;
  level_t      cur_level;

  dvfs_governor dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .util_percent (util_percent),
    .util_valid   (util_valid),
    .enable       (enable),
    .err_clr      (err_clr),
    .vr_req       (vr_req),
    .vr_level     (vr_level),
    .vr_ack       (vr_ack),
    .clk_req      (clk_req),
    .clk_level    (clk_level),
    .clk_ack      (clk_ack),
    .cur_level    (cur_level),
    .busy         (busy),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  localparam int V = 0;
  localparam int F = 1;

  // Model: a transition is a queue of pending handshake steps.
  int m_lvl, m_tgt, m_vrl, m_clkl, m_up, m_dn, m_wait;
  bit m_fault;
  int m_steps[$];

  bit ack_auto = 1'b0;
  bit stray = 1'b0;
  int vr_dly = 0;
  int clk_dly = 0;

  function automatic void chk(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endfunction

  function automatic int head();
    return (m_steps.size() > 0) ? m_steps[0] : -1;
  endfunction

  function automatic void model_reset();
    m_lvl = 0; m_tgt = 0; m_vrl = 0; m_clkl = 0;
    m_up = 0; m_dn = 0; m_wait = 0; m_fault = 1'b0;
    m_steps.delete();
  endfunction

  function automatic void head_level();
    if (head() == V) m_vrl = m_tgt;
    else if (head() == F) m_clkl = m_tgt;
  endfunction

  function automatic void model_step();
    int u;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (m_fault) begin
      if (err_clr) begin
        m_fault = 1'b0; m_up = 0; m_dn = 0;
      end
      return;
    end
    if (m_steps.size() == 0) begin
      if (util_valid) begin
        u = (util_percent > 100) ? 100 : int'(util_percent);
        if (u >= 80) begin
          m_up = (m_up < 2) ? m_up + 1 : 2; m_dn = 0;
        end else if (u <= 30) begin
          m_dn = (m_dn < 4) ? m_dn + 1 : 4; m_up = 0;
        end else begin
          m_up = 0; m_dn = 0;
        end
        if (enable && u >= 80 && m_up == 2 && m_lvl < 3) begin
          m_tgt = m_lvl + 1; m_steps = {V, F};
        end else if (enable && u <= 30 && m_dn == 4 && m_lvl > 0) begin
          m_tgt = m_lvl - 1; m_steps = {F, V};
        end
        if (m_steps.size() > 0) begin
          m_up = 0; m_dn = 0; m_wait = 0;
          head_level();
        end
      end
      return;
    end
    if ((head() == V && vr_ack) || (head() == F && clk_ack)) begin
      void'(m_steps.pop_front());
      m_wait = 0;
      if (m_steps.size() == 0) m_lvl = m_tgt;
      else head_level();
    end else if (m_wait == 255 - 1) begin
      m_steps.delete();
      m_fault = 1'b1;
    end else begin
      m_wait++;
    end
  endfunction

  function automatic void compare_all();
    chk("vr_req", int'(vr_req), int'(head() == V));
    chk("clk_req", int'(clk_req), int'(head() == F));
    chk("vr_level", int'(vr_level), m_vrl);
    chk("clk_level", int'(clk_level), m_clkl);
    chk("cur_level", int'(cur_level), m_lvl);
    chk("busy", int'(busy), int'(m_steps.size() > 0));
    chk("timeout_err", int'(timeout_err), int'(m_fault));
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
    vr_ack = 1'b0;
    clk_ack = 1'b0;
    if (ack_auto) begin
      if (vr_req) begin
        if (vr_dly == 0) begin
          vr_ack = 1'b1; vr_dly = $urandom_range(0, 4);
        end else vr_dly--;
      end
      if (clk_req) begin
        if (clk_dly == 0) begin
          clk_ack = 1'b1; clk_dly = $urandom_range(0, 4);
        end else clk_dly--;
      end
    end
    if (stray) begin
      if (!vr_req && $urandom_range(0, 9) == 0) vr_ack = 1'b1;
      if (!clk_req && $urandom_range(0, 9) == 0) clk_ack = 1'b1;
    end
  endtask

  task automatic sample(int v);
    util_percent = 16'(v);
    util_valid = 1'b1;
    tick();
    util_valid = 1'b0;
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    chk("rst_cur_level", int'(cur_level), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_vr_req", int'(vr_req), 0);
    chk("rst_err", int'(timeout_err), 0);

    sample(85); sample(85);
    chk("up_vr_req", int'(vr_req), 1);
    chk("up_vr_level", int'(vr_level), 1);
    vr_ack = 1'b1; tick();
    chk("up_clk_req", int'(clk_req), 1);
    chk("up_clk_level", int'(clk_level), 1);
    chk("up_vr_dropped", int'(vr_req), 0);
    chk("up_cur_held", int'(cur_level), 0);
    clk_ack = 1'b1; tick();
    chk("up_cur_level", int'(cur_level), 1);
    chk("up_idle", int'(busy), 0);

    repeat (4) sample(20);
    chk("dn_clk_req", int'(clk_req), 1);
    chk("dn_clk_level", int'(clk_level), 0);
    chk("dn_vr_idle", int'(vr_req), 0);
    clk_ack = 1'b1; tick();
    chk("dn_vr_req", int'(vr_req), 1);
    chk("dn_vr_level", int'(vr_level), 0);
    chk("dn_cur_held", int'(cur_level), 1);
    vr_ack = 1'b1; tick();
    chk("dn_cur_level", int'(cur_level), 0);

    sample(85); sample(50); sample(85); tick();
    chk("mid_no_req", int'(busy), 0);
    repeat (3) sample(10); tick();
    chk("floor_no_req", int'(busy), 0);

    sample(85); sample(85);
    repeat (254) tick();
    chk("tmo_still_req", int'(vr_req), 1);
    tick();
    chk("tmo_req_drop", int'(vr_req), 0);
    chk("tmo_err", int'(timeout_err), 1);
    chk("tmo_cur", int'(cur_level), 0);
    repeat (3) sample(90);
    chk("fault_ignores", int'(vr_req), 0);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("err_cleared", int'(timeout_err), 0);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("err_clr_idle", int'(busy), 0);

    sample(85); sample(85);
    repeat (254) tick();
    vr_ack = 1'b1; tick();
    chk("late_ack_wins", int'(clk_req), 1);
    chk("late_ack_no_err", int'(timeout_err), 0);
    clk_ack = 1'b1; tick();
    chk("late_ack_lvl", int'(cur_level), 1);

    enable = 1'b0;
    repeat (5) sample(500);
    chk("disabled_no_req", int'(busy), 0);
    enable = 1'b1;
    sample(500);
    chk("sat_vr_req", int'(vr_req), 1);
    chk("sat_vr_level", int'(vr_level), 2);
    vr_ack = 1'b1; tick();
    clk_ack = 1'b1; tick();
    chk("sat_cur_level", int'(cur_level), 2);
    sample(100); sample(100);
    vr_ack = 1'b1; tick();
    chk("fu_clk_level", int'(clk_level), 3);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("mid_rst_cur", int'(cur_level), 0);
    chk("mid_rst_clk_req", int'(clk_req), 0);
    chk("mid_rst_clk_level", int'(clk_level), 0);
    chk("mid_rst_vr_level", int'(vr_level), 0);
    clk_ack = 1'b1; tick();
    chk("stray_ack_busy", int'(busy), 0);
    chk("stray_ack_cur", int'(cur_level), 0);

    stray = 1'b1;
    for (int seg = 0; seg < 12; seg++) begin
      ack_auto = ($urandom_range(0, 4) != 0);
      for (int c = 0; c < 250; c++) begin
        int r;
        r = $urandom_range(0, 3);
        util_valid = 1'($urandom_range(0, 1));
        case (r)
          0: util_percent = 16'($urandom_range(80, 100));
          1: util_percent = 16'($urandom_range(101, 65535));
          2: util_percent = 16'($urandom_range(0, 30));
          default: util_percent = 16'($urandom_range(31, 79));
        endcase
        enable = ($urandom_range(0, 9) != 0);
        err_clr = ($urandom_range(0, 39) == 0);
        rst_n = ($urandom_range(0, 499) != 0);
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
